// File: rtl/uart_pkg.sv
// uart_pkg: parity codes, TX/RX state encodings and period/width helpers for uart_xcvr.
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    function automatic int baud_period(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
    function automatic int cnt_width(input int period);
        return $clog2(period) + 1;
    endfunction
    // Zero padding above the payload does not change the result.
    function automatic logic parity_bit(input logic [7:0] data, input int parity);
        return parity == PARITY_EVEN ? ^data : ~^data;
    endfunction
endpackage

// File: rtl/uart_if.sv
// uart_if: fabric-side byte streams of uart_xcvr.
//   tx_data/tx_valid/tx_ready : byte to send, valid/ready handshake
//   rx_data/rx_valid/rx_ready : received byte, held until accepted
//   rx_perr/rx_ferr           : parity/framing error qualifying rx_data
//   rx_ovr                    : one-cycle pulse, frame dropped while rx_valid set
// master = fabric logic, slave = uart_xcvr.
interface uart_if #(parameter int DATA_BITS = 8) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_ovr;
    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_perr, rx_ferr, rx_ovr
    );
    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_perr, rx_ferr, rx_ovr
    );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: rx synchroniser, receive FSM and holding register.
//   clk, rst            : clock, synchronous active-high reset
//   rx                  : asynchronous serial input, idle high
//   rx_data/rx_valid    : received byte, held until rx_valid && rx_ready
//   rx_ready            : consumer accept
//   rx_perr/rx_ferr     : error flags travelling with rx_data
//   rx_ovr              : one-cycle pulse when a frame is dropped
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int PERIOD    = 8,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PARITY_NONE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_ovr
);
    localparam int CW = cnt_width(PERIOD);
    localparam int BW = $clog2(DATA_BITS + 1);
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] sh;
    logic                 s1, s2, prev, pbit;
    logic                 tick, fall, shift_en, par_en, done, frame_perr, frame_ferr;
    // Falling edge needs the line seen high first, so a stuck-low line never re-arms.
    assign fall = prev & ~s2;
    // START ticks at mid start bit; every later tick is one full period on.
    assign tick = state == RX_START ? cnt == CW'(PERIOD / 2 - 1) : cnt == CW'(PERIOD - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, prev} <= 3'b111;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            pbit     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            {s1, s2, prev} <= {rx, s1, s2};
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sh      <= shift_en ? {s2, sh[DATA_BITS-1:1]} : sh;
            pbit    <= par_en ? s2 : pbit;
            rx_ovr  <= done && rx_valid && !rx_ready;
            // A frame finishing in the accept cycle replaces the old one.
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= sh;
                rx_perr  <= frame_perr;
                rx_ferr  <= frame_ferr;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        bit_n   = bit_idx;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (fall) state_n = RX_START;
            end
            RX_START:  if (tick) state_n = s2 ? RX_IDLE : RX_DATA;
            RX_DATA: if (tick) begin
                bit_n = bit_idx + 1'b1;
                if (bit_idx == BW'(DATA_BITS - 1)) state_n = PARITY == PARITY_NONE ? RX_STOP : RX_PARITY;
            end
            RX_PARITY: if (tick) state_n = RX_STOP;
            RX_STOP:   if (tick) state_n = RX_IDLE;
            default:   state_n = RX_IDLE;
        endcase
    end
    always_comb begin
        shift_en   = state == RX_DATA && tick;
        par_en     = state == RX_PARITY && tick;
        done       = state == RX_STOP && tick;
        frame_perr = PARITY == PARITY_NONE ? 1'b0 : pbit != parity_bit(8'(sh), PARITY);
        frame_ferr = ~s2;
    end
endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART with framed TX/RX and valid/ready byte streams.
//   clk, rst : clock, synchronous active-high reset
//   rx       : serial input, asynchronous, idle high
//   tx       : serial output, registered, idle high
//   bus      : uart_if slave (tx stream in, rx stream and error flags out)
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 8000000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = PARITY_NONE,
    parameter int STOP_BITS     = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rx,
    output logic   tx,
    uart_if.slave  bus
);
    localparam int PERIOD = baud_period(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int CW     = cnt_width(PERIOD);
    localparam int BW     = $clog2(DATA_BITS + 1);
    if (PERIOD < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("uart_xcvr: unsupported parameter combination");
    end
    tx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] buf_q, data_sh;
    logic                 tick, tx_d;
    assign tick = cnt == CW'(PERIOD - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            buf_q   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            tx      <= tx_d;
            if (state == TX_IDLE && bus.tx_valid) buf_q <= bus.tx_data;
        end
    end
    // bit_idx counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        bit_n   = bit_idx;
        case (state)
            TX_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (bus.tx_valid) state_n = TX_START;
            end
            TX_START: if (tick) state_n = TX_DATA;
            TX_DATA: if (tick) begin
                bit_n = bit_idx + 1'b1;
                if (bit_idx == BW'(DATA_BITS - 1)) begin
                    bit_n   = '0;
                    state_n = PARITY == PARITY_NONE ? TX_STOP : TX_PARITY;
                end
            end
            TX_PARITY: if (tick) state_n = TX_STOP;
            TX_STOP: if (tick) begin
                bit_n = bit_idx + 1'b1;
                if (bit_idx == BW'(STOP_BITS - 1)) state_n = TX_IDLE;
            end
            default: state_n = TX_IDLE;
        endcase
    end
    // tx is registered from the next state so the line changes with the state.
    always_comb begin
        bus.tx_ready = state == TX_IDLE;
        data_sh      = buf_q >> bit_n;
        tx_d         = state_n == TX_START  ? 1'b0 :
                       state_n == TX_DATA   ? data_sh[0] :
                       state_n == TX_PARITY ? parity_bit(8'(buf_q), PARITY) : 1'b1;
    end
    uart_rx_frame #(
        .PERIOD   (PERIOD),
        .DATA_BITS(DATA_BITS),
        .PARITY   (PARITY)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_data (bus.rx_data),
        .rx_valid(bus.rx_valid),
        .rx_ready(bus.rx_ready),
        .rx_perr (bus.rx_perr),
        .rx_ferr (bus.rx_ferr),
        .rx_ovr  (bus.rx_ovr)
    );
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: self-checking bench for uart_xcvr in 8O1, 7E2 and 8N1 at PERIOD=8.
module tb_uart_xcvr;
    localparam int P = 8;
    typedef struct {
        int data;
        bit bad_par;
        bit bad_stop;
        int exp_data;
        int exp_perr;
        int exp_ferr;
    } rx_vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1;
    logic tx_a, tx_b, tx_c;
    logic [7:0] td = 8'h00;
    logic tv = 1'b0;
    logic rdy_a = 1'b0;
    int sel = 0;
    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int cfg_nb[3]  = '{8, 7, 8};
    int cfg_par[3] = '{1, 2, 0};
    int cfg_st[3]  = '{1, 2, 1};
    logic tx_mon, rdy_mon;
    always #5 clk = ~clk;
    uart_if #(.DATA_BITS(8)) if_a ();
    uart_if #(.DATA_BITS(7)) if_b ();
    uart_if #(.DATA_BITS(8)) if_c ();
    uart_xcvr #(.CLOCK_FREQ_HZ(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_a (.clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .bus(if_a.slave));
    uart_xcvr #(.CLOCK_FREQ_HZ(800), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
        u_b (.clk(clk), .rst(rst), .rx(1'b1), .tx(tx_b), .bus(if_b.slave));
    uart_xcvr #(.CLOCK_FREQ_HZ(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_c (.clk(clk), .rst(rst), .rx(1'b1), .tx(tx_c), .bus(if_c.slave));
    assign if_a.tx_data  = td;
    assign if_b.tx_data  = td[6:0];
    assign if_c.tx_data  = td;
    assign if_a.tx_valid = tv && sel == 0;
    assign if_b.tx_valid = tv && sel == 1;
    assign if_c.tx_valid = tv && sel == 2;
    assign if_a.rx_ready = rdy_a;
    assign if_b.rx_ready = 1'b1;
    assign if_c.rx_ready = 1'b1;
    assign tx_mon  = sel == 0 ? tx_a : sel == 1 ? tx_b : tx_c;
    assign rdy_mon = sel == 0 ? if_a.tx_ready : sel == 1 ? if_b.tx_ready : if_c.tx_ready;
    always @(negedge clk) if (if_a.rx_ovr) ovr_cnt++;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // Line-level frame from the framing rules: start, LSB-first data, parity, stops.
    function automatic void make_frame(input int d, input int nb, input int par, input int st, output int q[$]);
        int ones = 0;
        q = {};
        q.push_back(0);
        for (int i = 0; i < nb; i++) begin
            q.push_back((d >> i) & 1);
            ones += (d >> i) & 1;
        end
        if (par == 1) q.push_back(ones % 2 == 0 ? 1 : 0);
        else if (par == 2) q.push_back(ones % 2);
        for (int i = 0; i < st; i++) q.push_back(1);
    endfunction
    // Send on instance s, optionally keeping tx_valid high for a follow-on frame.
    task automatic tx_send(input int s, input int d, input bit keep);
        int q[$];
        int bad = 0;
        int low = 0;
        sel = s;
        chk("tx_ready idle", int'(rdy_mon), 1);
        td = 8'(d);
        tv = 1'b1;
        step();
        if (!keep) tv = 1'b0;
        make_frame(d, cfg_nb[s], cfg_par[s], cfg_st[s], q);
        for (int i = 0; i < q.size(); i++)
            for (int j = 0; j < P; j++) begin
                if (int'(tx_mon) != q[i]) bad++;
                if (!rdy_mon) low++;
                step();
            end
        chk("tx bit errors", bad, 0);
        chk("tx_ready low clocks", low, q.size() * P);
        chk("tx_ready back", int'(rdy_mon), 1);
        chk("tx idle high", int'(tx_mon), 1);
    endtask
    task automatic rx_send(input int d, input bit bad_par, input bit bad_stop);
        int q[$];
        make_frame(d, 8, 1, 1, q);
        if (bad_par) q[9] = 1 - q[9];
        if (bad_stop) q[10] = 0;
        for (int i = 0; i < q.size(); i++) begin
            rx_a = q[i][0];
            repeat (P) step();
        end
        rx_a = 1'b1;
        repeat (2 * P) step();
    endtask
    task automatic rx_expect(input string name, input int d, input int perr, input int ferr);
        chk({name, " valid"}, int'(if_a.rx_valid), 1);
        chk({name, " data"}, int'(if_a.rx_data), d);
        chk({name, " perr"}, int'(if_a.rx_perr), perr);
        chk({name, " ferr"}, int'(if_a.rx_ferr), ferr);
    endtask
    task automatic rx_accept();
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;
        chk("rx_valid cleared", int'(if_a.rx_valid), 0);
    endtask
    initial begin
        rx_vec_t tab[4];
        int seen;
        int base;
        tab[0] = '{data: 'h5A, bad_par: 0, bad_stop: 0, exp_data: 'h5A, exp_perr: 0, exp_ferr: 0};
        tab[1] = '{data: 'hA5, bad_par: 0, bad_stop: 0, exp_data: 'hA5, exp_perr: 0, exp_ferr: 0};
        tab[2] = '{data: 'h3C, bad_par: 0, bad_stop: 1, exp_data: 'h3C, exp_perr: 0, exp_ferr: 1};
        tab[3] = '{data: 'hC3, bad_par: 1, bad_stop: 0, exp_data: 'hC3, exp_perr: 1, exp_ferr: 0};
        repeat (3) step();
        chk("reset tx a", int'(tx_a), 1);
        chk("reset tx b", int'(tx_b), 1);
        chk("reset tx c", int'(tx_c), 1);
        chk("reset tx_ready", int'(if_a.tx_ready), 1);
        chk("reset rx_valid", int'(if_a.rx_valid), 0);
        chk("reset rx_data", int'(if_a.rx_data), 0);
        chk("reset flags", int'({if_a.rx_perr, if_a.rx_ferr, if_a.rx_ovr}), 0);
        rst = 1'b0;
        step();
        tx_send(2, 'h35, 1'b0);
        tx_send(1, 'h41, 1'b1);
        tx_send(1, 'h2A, 1'b0);
        rx_a = 1'b0;
        repeat (3) step();
        rx_a = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 * P; i++) begin
            if (if_a.rx_valid) seen++;
            step();
        end
        chk("glitch no rx_valid", seen, 0);
        foreach (tab[k]) begin
            rx_send(tab[k].data, tab[k].bad_par, tab[k].bad_stop);
            rx_expect("rx table", tab[k].exp_data, tab[k].exp_perr, tab[k].exp_ferr);
            repeat (2 * P) step();
            chk("rx held valid", int'(if_a.rx_valid), 1);
            chk("rx held data", int'(if_a.rx_data), tab[k].exp_data);
            rx_accept();
        end
        chk("no spurious ovr", ovr_cnt, 0);
        base = ovr_cnt;
        rx_send('h11, 1'b0, 1'b0);
        rx_send('h22, 1'b0, 1'b0);
        chk("ovr pulses", ovr_cnt - base, 1);
        rx_expect("ovr kept", 'h11, 0, 0);
        rx_accept();
        for (int n = 0; n < 16; n++) begin
            int d = int'($urandom_range(0, 255));
            bit bp = $urandom_range(0, 3) == 0;
            bit bs = $urandom_range(0, 3) == 0;
            rx_send(d, bp, bs);
            rx_expect("rx random", d, int'(bp), int'(bs));
            rx_accept();
        end
        for (int n = 0; n < 12; n++)
            tx_send(int'($urandom_range(0, 2)), int'($urandom_range(0, 255)), 1'b0);
        sel = 2;
        td = 8'h35;
        tv = 1'b1;
        step();
        tv = 1'b0;
        repeat (30) step();
        chk("mid-frame tx busy", int'(rdy_mon), 0);
        rst = 1'b1;
        step();
        chk("rst tx high", int'(tx_mon), 1);
        chk("rst tx_ready", int'(rdy_mon), 1);
        rst = 1'b0;
        step();
        tx_send(2, 'hC6, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end
endmodule
